// File: rtl/pia_input_conditioner.sv
// rtl/pia_input_conditioner.sv - two-flop sync and E-tick debounce for mc6821 switch inputs; optional press latch via PIA_INPUT_LATCH_EN
module pia_input_conditioner #(
    parameter int                 WIDTH          = 8,
    parameter int                 DEBOUNCE_TICKS = 16,
    parameter logic [WIDTH-1:0]   RESET_VALUE    = 8'hFF,
    parameter int                 CA1_BIT        = 0,
    parameter int                 CB1_BIT        = 1,
    parameter logic [WIDTH-1:0]   LATCH_MASK     = 8'h00
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             e_sync,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             read_ack,
    output logic [WIDTH-1:0] port_out,
    output logic [WIDTH-1:0] changed,
    output logic             ca1,
    output logic             cb1
);

    localparam int CNT_W = $clog2(DEBOUNCE_TICKS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // A bounce back to the stable level restarts the count from zero.
    always_comb begin
        stable_d  = stable_q;
        changed_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (e_sync) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i]  = sync2_q[i];
                    cnt_d[i]     = '0;
                    changed_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= RESET_VALUE;
            sync2_q   <= RESET_VALUE;
            stable_q  <= RESET_VALUE;
            changed_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= raw_in;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef PIA_INPUT_LATCH_EN
    logic [WIDTH-1:0] latch_q, latch_d;
    logic [WIDTH-1:0] press;

    // A press landing in the same clock as read_ack survives the clear.
    always_comb begin
        press   = stable_q & ~stable_d & LATCH_MASK;
        latch_d = (read_ack ? '0 : latch_q) | press;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            latch_q <= '0;
        end else begin
            latch_q <= latch_d;
        end
    end

    assign port_out = stable_q & ~latch_q;
`else
    logic unused_latch_inputs;
    assign unused_latch_inputs = ^{read_ack, LATCH_MASK};
    assign port_out = stable_q;
`endif

    assign changed = changed_q;
    assign ca1     = stable_q[CA1_BIT];
    assign cb1     = stable_q[CB1_BIT];

endmodule

// File: tb/tb_pia_input_conditioner.sv
// tb/tb_pia_input_conditioner.sv - randomized bench for pia_input_conditioner against a windowed-history debounce model
module tb_pia_input_conditioner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, e16, e1, read_ack;
    logic [7:0] raw;
    logic [7:0] po16, ch16, po1, ch1;
    logic       ca16, cb16, ca1x, cb1x;

    pia_input_conditioner #(.WIDTH(8), .DEBOUNCE_TICKS(16), .RESET_VALUE(8'hFF),
        .CA1_BIT(0), .CB1_BIT(1), .LATCH_MASK(8'h01)) dut16 (
        .clock(clk), .reset(reset), .e_sync(e16), .raw_in(raw), .read_ack(read_ack),
        .port_out(po16), .changed(ch16), .ca1(ca16), .cb1(cb16));

    pia_input_conditioner #(.WIDTH(8), .DEBOUNCE_TICKS(1), .RESET_VALUE(8'hFF),
        .CA1_BIT(0), .CB1_BIT(1), .LATCH_MASK(8'h01)) dut1 (
        .clock(clk), .reset(reset), .e_sync(e1), .raw_in(raw), .read_ack(read_ack),
        .port_out(po1), .changed(ch1), .ca1(ca1x), .cb1(cb1x));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a bit flips once its last T e_sync samples all disagree with it.
    logic [7:0] m_r1, m_r2;
    logic [7:0] m_hist [2][16];
    int         m_nh [2];
    logic [7:0] m_stable [2];
    logic [7:0] m_latch [2];
    logic [7:0] m_chg [2];

    task automatic model_inst(input int k, input int t, input logic e, input logic [7:0] samp);
        logic [7:0] nxt;
        logic [7:0] press;
        logic       all_diff;
        nxt      = m_stable[k];
        press    = '0;
        m_chg[k] = '0;
        if (e) begin
            for (int j = 15; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
            m_hist[k][0] = samp;
            if (m_nh[k] < 16) m_nh[k]++;
            for (int b = 0; b < 8; b++) begin
                if (m_nh[k] >= t) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < t; j++)
                        if (m_hist[k][j][b] == m_stable[k][b]) all_diff = 1'b0;
                    if (all_diff) begin
                        nxt[b]      = ~m_stable[k][b];
                        m_chg[k][b] = 1'b1;
                    end
                end
            end
            press = m_stable[k] & ~nxt & 8'h01;
            m_stable[k] = nxt;
        end
        if (read_ack) m_latch[k] = '0;
        m_latch[k] = m_latch[k] | press;
    endtask

    task automatic model_edge();
        logic [7:0] samp;
        if (reset) begin
            m_r1 = 8'hFF;
            m_r2 = 8'hFF;
            for (int k = 0; k < 2; k++) begin
                m_nh[k] = 0;
                m_stable[k] = 8'hFF;
                m_latch[k] = '0;
                m_chg[k] = '0;
            end
        end else begin
            samp = m_r2;
            m_r2 = m_r1;
            m_r1 = raw;
            model_inst(0, 16, e16, samp);
            model_inst(1, 1, e1, samp);
        end
    endtask

    function automatic logic [7:0] exp_po(input int k);
`ifdef PIA_INPUT_LATCH_EN
        return m_stable[k] & ~m_latch[k];
`else
        return m_stable[k];
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("po16", po16, exp_po(0));
        check("chg16", ch16, m_chg[0]);
        check("ca1_16", {7'd0, ca16}, {7'd0, m_stable[0][0]});
        check("cb1_16", {7'd0, cb16}, {7'd0, m_stable[0][1]});
        check("po1", po1, exp_po(1));
        check("chg1", ch1, m_chg[1]);
        check("ca1_1", {7'd0, ca1x}, {7'd0, m_stable[1][0]});
        check("cb1_1", {7'd0, cb1x}, {7'd0, m_stable[1][1]});
    endtask

    int  phase = 0;
    bit  e_en  = 1'b1;

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            phase++;
            e16 = e_en && (phase % 12 == 0);
            e1  = e_en;
            cycle();
        end
    endtask

    logic [7:0] sw;
    logic [7:0] exp_coin;

    initial begin
        reset = 1'b1; raw = 8'h00; e16 = 1'b0; e1 = 1'b0; read_ack = 1'b0;
        m_r1 = 8'hFF; m_r2 = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            m_nh[k] = 0; m_stable[k] = 8'hFF; m_latch[k] = '0; m_chg[k] = '0;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_po16", po16, 8'hFF);
            check("rst_po1", po1, 8'hFF);
        end
        reset = 1'b0; raw = 8'hFF;
        run(30);

        raw = 8'hF7;
        run(220);
        check("t2_bit3_low", {7'd0, po16[3]}, 8'd0);

        raw = 8'hFF; run(220);
        raw = 8'hFE; run(120);
        check("t3_glitch_hold", {7'd0, po16[0]}, 8'd1);
        raw = 8'hFF; run(12);
        raw = 8'hFE; run(200);
        check("t3_bit0_low", {7'd0, ca16}, 8'd0);

        raw = 8'hFF; read_ack = 1'b1; run(1); read_ack = 1'b0;
        run(220);
        raw = 8'hFB; run(125);
        reset = 1'b1; run(2); reset = 1'b0;
        run(150);
        check("t5_recount", {7'd0, po16[2]}, 8'd1);
        run(80);
        check("t5_fall", {7'd0, po16[2]}, 8'd0);

        e_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            raw = 8'($urandom);
            run(1);
        end
        e_en = 1'b1; raw = 8'hFF; read_ack = 1'b1; run(1); read_ack = 1'b0;
        run(250);

`ifdef PIA_INPUT_LATCH_EN
        exp_coin = 8'd0;
`else
        exp_coin = 8'd1;
`endif
        raw = 8'hFE; run(1);
        raw = 8'hFF; run(6);
        check("coin_held", {7'd0, po1[0]}, exp_coin);
        read_ack = 1'b1; run(1); read_ack = 1'b0; run(1);
        check("coin_cleared", {7'd0, po1[0]}, 8'd1);
        raw = 8'hFE; run(1);
        raw = 8'hFF; run(1);
        read_ack = 1'b1; run(1); read_ack = 1'b0;
        run(3);
        check("coin_vs_ack", {7'd0, po1[0]}, exp_coin);

        sw = 8'hFF;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 199) == 0) sw[$urandom_range(0, 7)] ^= 1'b1;
            raw = sw;
            if ($urandom_range(0, 29) == 0) raw[$urandom_range(0, 7)] ^= 1'b1;
            read_ack = ($urandom_range(0, 19) == 0);
            reset    = ($urandom_range(0, 1499) == 0);
            e_en     = ($urandom_range(0, 9) != 0);
            run(1);
        end
        reset = 1'b0; read_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
